// File: rtl/change_evt_sched.sv
// change_evt_sched: multi-channel change-event scheduler.
//
// Watches NCH input words. On every clock-enabled sample cycle it compares each word
// with its previously sampled value, records a change as a per-channel pending entry,
// and hands the entries one at a time to a valid/ready consumer through a round-robin
// arbiter.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   ce             sample enable; detection happens only when ce=1
//   i              channel words, channel k at [k*WID +: WID]
//   mask           1 = suppress new detections on that channel
//   evt_valid/     event handshake (valid/ready)
//   evt_ready
//   evt_ch         channel index of the presented event
//   evt_val        newest value of that channel when it was granted
//   evt_prev       value of that channel before its first unreported change
//   pending        per-channel change queued, not yet granted
//   ovf            sticky: a change was coalesced into an already-pending entry
//   ovf_clr        clears all ovf bits (a same-cycle set wins)
//
// Optional build macro CHG_TIMESTAMP_EN: adds parameter TSW, a free-running TSW-bit
// counter, per-channel capture of the counter on the detection that sets pending,
// and output evt_ts latched at grant.

module change_evt_sched #(
  parameter int unsigned NCH  = 4,
  parameter int unsigned WID  = 8,
  parameter int unsigned IDXW = 2
`ifdef CHG_TIMESTAMP_EN
  ,
  parameter int unsigned TSW  = 16
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ce,
  input  logic [NCH*WID-1:0] i,
  input  logic [NCH-1:0]     mask,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic [IDXW-1:0]    evt_ch,
  output logic [WID-1:0]     evt_val,
  output logic [WID-1:0]     evt_prev,
  output logic [NCH-1:0]     pending,
  output logic [NCH-1:0]     ovf,
  input  logic               ovf_clr
`ifdef CHG_TIMESTAMP_EN
  ,
  output logic [TSW-1:0]     evt_ts
`endif
);

  typedef enum logic {
    StIdle,
    StPresent
  } state_e;

  // Per-channel storage
  logic [WID-1:0] in_w   [NCH];
  logic [WID-1:0] hold_q [NCH];
  logic [WID-1:0] hold_d [NCH];
  logic [WID-1:0] snap_q [NCH];
  logic [WID-1:0] snap_d [NCH];
  logic [WID-1:0] prv_q  [NCH];
  logic [WID-1:0] prv_d  [NCH];
  logic [NCH-1:0] pending_q, pending_d;
  logic [NCH-1:0] ovf_q, ovf_d;
  logic [NCH-1:0] det;

  // Arbiter state
  state_e         state_q, state_d;
  logic [IDXW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDXW-1:0] evt_ch_q, evt_ch_d;
  logic [WID-1:0]  evt_val_q, evt_val_d;
  logic [WID-1:0]  evt_prev_q, evt_prev_d;

  logic            grant_any;
  logic [IDXW-1:0] grant_idx;
  logic            grant_fire;
  logic [NCH-1:0]  grant_oh;

`ifdef CHG_TIMESTAMP_EN
  logic [TSW-1:0] ts_cnt_q, ts_cnt_d;
  logic [TSW-1:0] ts_q [NCH];
  logic [TSW-1:0] ts_d [NCH];
  logic [TSW-1:0] evt_ts_q, evt_ts_d;
`endif

  // Unpack the flat input bus and detect changes against the last sampled value.
  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      in_w[k] = i[k*WID +: WID];
      det[k]  = ce & ~mask[k] & (in_w[k] != hold_q[k]);
    end
  end

  // Round-robin search: first pending channel at or after rr_ptr, wrapping modulo NCH
  // (not modulo 2^IDXW).
  always_comb begin : grant_search
    int unsigned c;
    grant_any = 1'b0;
    grant_idx = '0;
    c         = 0;
    for (int unsigned n = 0; n < NCH; n++) begin
      c = 32'(rr_ptr_q) + n;
      if (c >= NCH) begin
        c = c - NCH;
      end
      if (!grant_any && pending_q[c]) begin
        grant_any = 1'b1;
        grant_idx = IDXW'(c);
      end
    end
  end

  assign grant_fire = (state_q == StIdle) && grant_any;

  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      grant_oh[k] = grant_fire && (grant_idx == IDXW'(k));
    end
  end

  // Per-channel pending/snapshot/overflow bookkeeping.
  always_comb begin
    hold_d    = hold_q;
    snap_d    = snap_q;
    prv_d     = prv_q;
    pending_d = pending_q;
    ovf_d     = ovf_clr ? '0 : ovf_q;
`ifdef CHG_TIMESTAMP_EN
    ts_d      = ts_q;
`endif
    for (int k = 0; k < NCH; k++) begin
      if (ce) begin
        hold_d[k] = in_w[k];
      end
      if (det[k]) begin
        snap_d[k] = in_w[k];
        // An entry being granted this cycle is already gone from the consumer's point of
        // view, so a change now starts a fresh entry rather than coalescing.
        if (!pending_q[k] || grant_oh[k]) begin
          pending_d[k] = 1'b1;
          prv_d[k]     = hold_q[k];
`ifdef CHG_TIMESTAMP_EN
          ts_d[k]      = ts_cnt_q;
`endif
        end else begin
          ovf_d[k] = 1'b1;
        end
      end else if (grant_oh[k]) begin
        pending_d[k] = 1'b0;
      end
    end
  end

  // Arbiter FSM: IDLE grants and latches the event, PRESENT holds it until accepted.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    evt_ch_d   = evt_ch_q;
    evt_val_d  = evt_val_q;
    evt_prev_d = evt_prev_q;
`ifdef CHG_TIMESTAMP_EN
    evt_ts_d   = evt_ts_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (grant_any) begin
          state_d    = StPresent;
          evt_ch_d   = grant_idx;
          evt_val_d  = snap_q[grant_idx];
          evt_prev_d = prv_q[grant_idx];
`ifdef CHG_TIMESTAMP_EN
          evt_ts_d   = ts_q[grant_idx];
`endif
        end
      end
      StPresent: begin
        if (evt_ready) begin
          state_d  = StIdle;
          rr_ptr_d = (evt_ch_q == IDXW'(NCH - 1)) ? '0 : evt_ch_q + IDXW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef CHG_TIMESTAMP_EN
  assign ts_cnt_d = ts_cnt_q + TSW'(1);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      // Current inputs become the baseline so they are never reported as changes.
      hold_q     <= in_w;
      snap_q     <= '{default: '0};
      prv_q      <= '{default: '0};
      pending_q  <= '0;
      ovf_q      <= '0;
      state_q    <= StIdle;
      rr_ptr_q   <= '0;
      evt_ch_q   <= '0;
      evt_val_q  <= '0;
      evt_prev_q <= '0;
`ifdef CHG_TIMESTAMP_EN
      ts_cnt_q   <= '0;
      ts_q       <= '{default: '0};
      evt_ts_q   <= '0;
`endif
    end else begin
      hold_q     <= hold_d;
      snap_q     <= snap_d;
      prv_q      <= prv_d;
      pending_q  <= pending_d;
      ovf_q      <= ovf_d;
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      evt_ch_q   <= evt_ch_d;
      evt_val_q  <= evt_val_d;
      evt_prev_q <= evt_prev_d;
`ifdef CHG_TIMESTAMP_EN
      ts_cnt_q   <= ts_cnt_d;
      ts_q       <= ts_d;
      evt_ts_q   <= evt_ts_d;
`endif
    end
  end

  assign evt_valid = (state_q == StPresent);
  assign evt_ch    = evt_ch_q;
  assign evt_val   = evt_val_q;
  assign evt_prev  = evt_prev_q;
  assign pending   = pending_q;
  assign ovf       = ovf_q;
`ifdef CHG_TIMESTAMP_EN
  assign evt_ts    = evt_ts_q;
`endif

endmodule

// File: tb/tb_change_evt_sched.sv
module tb_change_evt_sched;

  localparam int NCH  = 4;
  localparam int WID  = 8;
  localparam int IDXW = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic               ce;
  logic [NCH*WID-1:0] i_v;
  logic [NCH-1:0]     mask;
  logic               evt_valid;
  logic               evt_ready;
  logic [IDXW-1:0]    evt_ch;
  logic [WID-1:0]     evt_val;
  logic [WID-1:0]     evt_prev;
  logic [NCH-1:0]     pending;
  logic [NCH-1:0]     ovf;
  logic               ovf_clr;

  change_evt_sched #(
    .NCH (NCH),
    .WID (WID),
    .IDXW(IDXW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ce       (ce),
    .i        (i_v),
    .mask     (mask),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_ch   (evt_ch),
    .evt_val  (evt_val),
    .evt_prev (evt_prev),
    .pending  (pending),
    .ovf      (ovf),
    .ovf_clr  (ovf_clr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [IDXW-1:0] ch;
    logic [WID-1:0]  val;
    logic [WID-1:0]  prev;
  } exp_t;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input int k, input logic [WID-1:0] v);
    i_v[k*WID +: WID] = v;
  endtask

  task automatic push(input int ch, input logic [WID-1:0] v, input logic [WID-1:0] p);
    exp_t e;
    e.ch   = IDXW'(ch);
    e.val  = v;
    e.prev = p;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Wait (bounded) for an event, compare it with the scoreboard head, accept it and
  // confirm the post-handshake idle cycle.
  task automatic take_event(input string tag);
    int   n;
    exp_t e;
    n = 0;
    while (evt_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, 32'(evt_valid), 32'd1);
    if (evt_valid === 1'b1) begin
      check({tag, "_queued"}, 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check({tag, "_ch"}, 32'(evt_ch), 32'(e.ch));
        check({tag, "_val"}, 32'(evt_val), 32'(e.val));
        check({tag, "_prev"}, 32'(evt_prev), 32'(e.prev));
      end
      evt_ready = 1'b1;
      @(negedge clk);
      evt_ready = 1'b0;
      check({tag, "_bubble"}, 32'(evt_valid), 32'd0);
    end
  endtask

  initial begin
    rst       = 1'b1;
    ce        = 1'b1;
    evt_ready = 1'b0;
    ovf_clr   = 1'b0;
    mask      = '0;
    i_v       = '0;
    set_ch(2, 8'h11);
    @(negedge clk);
    @(negedge clk);
    check("rst_valid", 32'(evt_valid), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_ch", 32'(evt_ch), 32'd0);
    check("rst_val", 32'(evt_val), 32'd0);
    check("rst_prev", 32'(evt_prev), 32'd0);
    rst = 1'b0;

    // Test 1: initial values are not changes; single change latency.
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check("t1_quiet_valid", 32'(evt_valid), 32'd0);
      check("t1_quiet_pend", 32'(pending), 32'd0);
    end
    set_ch(2, 8'h5A);
    push(2, 8'h5A, 8'h11);
    @(negedge clk);
    check("t1_pend_set", 32'(pending), 32'h4);
    check("t1_not_yet", 32'(evt_valid), 32'd0);
    @(negedge clk);
    check("t1_valid_lat", 32'(evt_valid), 32'd1);
    check("t1_pend_clr", 32'(pending), 32'd0);
    take_event("t1_ev");

    // rr_ptr is now 3: ch3 wins over ch0.
    set_ch(0, 8'h10);
    set_ch(3, 8'h30);
    push(3, 8'h30, 8'h00);
    push(0, 8'h10, 8'h00);
    take_event("t1b_ev1");
    take_event("t1b_ev2");

    // Test 2: simultaneous changes after reset, one bubble between events.
    do_reset();
    set_ch(1, 8'h21);
    set_ch(3, 8'h43);
    push(1, 8'h21, 8'h00);
    push(3, 8'h43, 8'h30);
    take_event("t2_ev1");
    @(negedge clk);
    check("t2_one_bubble", 32'(evt_valid), 32'd1);
    take_event("t2_ev2");
    // rr_ptr wrapped to 0: ch0 wins over ch2.
    set_ch(0, 8'h11);
    set_ch(2, 8'h22);
    push(0, 8'h11, 8'h10);
    push(2, 8'h22, 8'h5A);
    take_event("t2b_ev1");
    take_event("t2b_ev2");

    // Test 3: coalescing while another event is held.
    set_ch(0, 8'h01);
    do_reset();
    set_ch(1, 8'h31);
    push(1, 8'h31, 8'h21);
    @(negedge clk);
    check("t3_pend1", 32'(pending), 32'h2);
    @(negedge clk);
    check("t3_valid", 32'(evt_valid), 32'd1);
    set_ch(0, 8'h02);
    @(negedge clk);
    check("t3_pend0", 32'(pending), 32'h1);
    set_ch(0, 8'h03);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check("t3_ovf_set_wins", 32'(ovf), 32'h1);
    check("t3_pend0_kept", 32'(pending), 32'h1);
    check("t3_hold_ch", 32'(evt_ch), 32'd1);
    check("t3_hold_val", 32'(evt_val), 32'h31);
    push(0, 8'h03, 8'h01);
    take_event("t3_ev1");
    take_event("t3_ev2");
    check("t3_ovf_sticky", 32'(ovf), 32'h1);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check("t3_ovf_clr", 32'(ovf), 32'd0);

    // Test 4: masked change is never reported.
    mask = 4'b0100;
    set_ch(2, 8'h77);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check("t4_mask_pend", 32'(pending), 32'd0);
    end
    mask = '0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      check("t4_unmask_valid", 32'(evt_valid), 32'd0);
      check("t4_unmask_pend", 32'(pending), 32'd0);
    end

    // Test 5: toggles with ce=0 are invisible.
    set_ch(0, 8'h00);
    push(0, 8'h00, 8'h03);
    take_event("t5_ev");
    ce = 1'b0;
    set_ch(0, 8'hFF);
    @(negedge clk);
    check("t5_ce0_pend", 32'(pending), 32'd0);
    set_ch(0, 8'h00);
    @(negedge clk);
    ce = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      check("t5_quiet_valid", 32'(evt_valid), 32'd0);
      check("t5_quiet_pend", 32'(pending), 32'd0);
    end

    // Test 6: reset while presenting discards everything.
    set_ch(2, 8'h88);
    @(negedge clk);
    @(negedge clk);
    check("t6_valid", 32'(evt_valid), 32'd1);
    check("t6_ch", 32'(evt_ch), 32'd2);
    set_ch(1, 8'h99);
    set_ch(3, 8'hAA);
    @(negedge clk);
    check("t6_pend", 32'(pending), 32'hA);
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_valid", 32'(evt_valid), 32'd0);
    check("t6_rst_pend", 32'(pending), 32'd0);
    check("t6_rst_ch", 32'(evt_ch), 32'd0);
    check("t6_rst_val", 32'(evt_val), 32'd0);
    check("t6_rst_prev", 32'(evt_prev), 32'd0);
    rst = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      check("t6_post_valid", 32'(evt_valid), 32'd0);
    end

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
